// File: rtl/hex_display_ctrl.sv
// Seven-segment display controller: hex or decimal rendering of a loaded
// value, leading-zero blanking, decimal overflow dashes and whole-display blink.
module hex_display_ctrl #(
  parameter int unsigned NDIG       = 4,
  parameter int unsigned BLINK_DIV  = 12_500_000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [4*NDIG-1:0]   load_value,
  input  logic                mode,
  input  logic                blank_lz,
  input  logic                blink_en,
  output logic                busy,
  output logic                overflow,
  output logic [7*NDIG-1:0]   hex
);

  localparam int unsigned VW = 4 * NDIG;
  localparam int unsigned BW = 4 * (NDIG + 2);
  localparam int unsigned CW = $clog2(VW + 1);
  localparam int unsigned PW = $clog2(BLINK_DIV);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic {IDLE, CONV} state_t;

  state_t          state, state_next;
  logic            accept;
  logic            conv_last;
  logic            conv_blz;
  logic [VW-1:0]   conv_bin, bin_sh;
  logic [BW-1:0]   conv_bcd, bcd_adj, bcd_sh;
  logic [CW-1:0]   conv_cnt;
  logic [VW-1:0]   shown;
  logic            shown_vld, shown_blz, shown_dash;
  logic [PW-1:0]   presc;
  logic            blink_phase;
  logic [7*NDIG-1:0] render;

  // Active-low segment code for one hex nibble (bit 0 = a, bit 6 = g).
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    case (nib)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

  assign load_ready = (state == IDLE);
  assign busy       = (state == CONV);
  assign accept     = load_valid && (state == IDLE);
  assign conv_last  = (conv_cnt == CW'(VW - 1));

  // State register.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_next;
  end

  // Next state: decimal accepts start a conversion, the final shift ends it.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept && mode) state_next = CONV;
      CONV: if (conv_last)      state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  // One shift-add-3 step: correct each BCD digit >= 5, then shift in the next bit.
  always_comb begin
    bcd_adj = conv_bcd;
    for (int unsigned i = 0; i < NDIG + 2; i++) begin
      if (conv_bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = conv_bcd[4*i +: 4] + 4'd3;
    end
    bcd_sh = {bcd_adj[BW-2:0], conv_bin[VW-1]};
    bin_sh = {conv_bin[VW-2:0], 1'b0};
  end

  // Load capture, conversion datapath and the currently displayed content.
  // Display content (digits, blanking mode, dash flag) is kept separate from the
  // load-time samples so the old picture stays intact while a conversion runs.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      conv_bin   <= '0;
      conv_bcd   <= '0;
      conv_cnt   <= '0;
      conv_blz   <= 1'b0;
      shown      <= '0;
      shown_vld  <= 1'b0;
      shown_blz  <= 1'b0;
      shown_dash <= 1'b0;
      overflow   <= 1'b0;
    end else if (accept) begin
      overflow <= 1'b0;
      if (mode) begin
        conv_bin <= load_value;
        conv_bcd <= '0;
        conv_cnt <= '0;
        conv_blz <= blank_lz;
      end else begin
        shown      <= load_value;
        shown_vld  <= 1'b1;
        shown_blz  <= blank_lz;
        shown_dash <= 1'b0;
      end
    end else if (state == CONV) begin
      conv_bin <= bin_sh;
      conv_bcd <= bcd_sh;
      conv_cnt <= conv_cnt + 1'b1;
      if (conv_last) begin
        shown      <= bcd_sh[VW-1:0];
        shown_vld  <= 1'b1;
        shown_blz  <= conv_blz;
        shown_dash <= |bcd_sh[BW-1:VW];
        overflow   <= |bcd_sh[BW-1:VW];
      end
    end
  end

  // Blink prescaler; held at zero while blinking is disabled.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N || !blink_en) begin
      presc       <= '0;
      blink_phase <= 1'b0;
    end else if (presc == PW'(BLINK_DIV - 1)) begin
      presc       <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Segment rendering: top-down scan tracks whether all higher digits are zero.
  always_comb begin
    logic        zero_above;
    logic [6:0]  seg;
    int unsigned k;
    render     = '0;
    zero_above = 1'b1;
    for (int unsigned i = 0; i < NDIG; i++) begin
      k          = NDIG - 1 - i;
      zero_above = zero_above && (shown[4*k +: 4] == 4'h0);
      if (!shown_vld || (blink_en && blink_phase)) seg = SEG_BLANK;
      else if (shown_dash)                          seg = SEG_DASH;
      else if (shown_blz && k != 0 && zero_above)   seg = SEG_BLANK;
      else                                          seg = seg7(shown[4*k +: 4]);
      render[7*k +: 7] = ACTIVE_LOW ? seg : ~seg;
    end
  end

  // Registered segment output.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) hex <= {NDIG{ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK}};
    else          hex <= render;
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Self-checking bench for hex_display_ctrl (NDIG=4, BLINK_DIV=4, active-low).
module tb_hex_display_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_value;
  logic        mode;
  logic        blank_lz;
  logic        blink_en;
  logic        busy;
  logic        overflow;
  logic [27:0] hex;

  localparam logic [27:0] ALL_BLANK = {4{7'h7F}};

  typedef struct {
    int          due;
    logic [27:0] hex;
    logic        ovf;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_err    = 0;

  hex_display_ctrl #(.NDIG(4), .BLINK_DIV(4), .ACTIVE_LOW(1'b1)) dut (
    .CLOCK_50   (clk),
    .RESET_N    (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .mode       (mode),
    .blank_lz   (blank_lz),
    .blink_en   (blink_en),
    .busy       (busy),
    .overflow   (overflow),
    .hex        (hex)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [6:0] seg7(input int unsigned d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10; 10: return 7'h08; 11: return 7'h03;
     12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  // Reference picture for a value in hex or decimal, with optional blanking.
  function automatic logic [27:0] exp_disp(input int unsigned v, input bit dec, input bit blz);
    int unsigned d[4];
    int unsigned div;
    int          msnz;
    logic [27:0] r;
    if (dec && v > 9999) return {4{7'h3F}};
    div  = 1;
    msnz = 0;
    for (int k = 0; k < 4; k++) begin
      d[k] = dec ? (v / div) % 10 : (v >> (4 * k)) & 15;
      div  = div * 10;
      if (d[k] != 0) msnz = k;
    end
    for (int k = 0; k < 4; k++) r[7*k +: 7] = (blz && k > msnz) ? 7'h7F : seg7(d[k]);
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Queue the picture the DUT must produce for a load accepted this cycle.
  task automatic push_exp(input int unsigned v, input bit md, input bit blz);
    exp_t e;
    e.due = cyc + (md ? 17 : 1);
    e.hex = exp_disp(v, md, blz);
    e.ovf = md && (v > 9999);
    e.tag = $sformatf("load_%s_%h", md ? "dec" : "hex", v[15:0]);
    sb.push_back(e);
  endtask

  task automatic do_load(input logic [15:0] v, input bit md, input bit blz, input bit push);
    load_value = v;
    mode       = md;
    blank_lz   = blz;
    load_valid = 1'b1;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    if (push) push_exp(v, md, blz);
  endtask

  // Output side of the scoreboard: compare when a queued result falls due.
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #1;
    if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      check({e.tag, "_hex"}, hex, e.hex);
      check({e.tag, "_ovf"}, overflow, e.ovf);
    end
  end

  initial begin
    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_value = '0;
    mode       = 1'b0;
    blank_lz   = 1'b0;
    blink_en   = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(10);
    check("reset_hex", hex, ALL_BLANK);
    check("reset_ready", load_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_ovf", overflow, 0);

    // Hex load, latency 1, stays ready.
    do_load(16'h1A3F, 1'b0, 1'b0, 1'b1);
    check("hex_ready_after_accept", load_ready, 1);
    tick(2);

    // Back-to-back hex loads with leading-zero blanking.
    load_value = 16'h000F; mode = 1'b0; blank_lz = 1'b1; load_valid = 1'b1;
    tick(1);
    push_exp(16'h000F, 1'b0, 1'b1);
    load_value = 16'h0000;
    tick(1);
    push_exp(16'h0000, 1'b0, 1'b1);
    load_valid = 1'b0;
    tick(2);

    // Decimal conversion: busy 16 cycles, old picture held, stray load ignored.
    do_load(16'h04D2, 1'b1, 1'b0, 1'b1);
    check("conv_busy_0", busy, 1);
    check("conv_ready_0", load_ready, 0);
    for (int k = 1; k <= 15; k++) begin
      if (k == 5) begin
        load_value = 16'h0001; mode = 1'b0; load_valid = 1'b1;
      end
      tick(1);
      load_valid = 1'b0;
      check($sformatf("conv_busy_%0d", k), busy, 1);
      check($sformatf("conv_ready_%0d", k), load_ready, 0);
      check($sformatf("conv_hold_%0d", k), hex, {{3{7'h7F}}, 7'h40});
    end
    tick(1);
    check("conv_done_busy", busy, 0);
    check("conv_done_ready", load_ready, 1);
    tick(2);

    // Decimal overflow, then cleared by the next accept.
    do_load(16'hFFFF, 1'b1, 1'b0, 1'b1);
    tick(17);
    check("ovf_set", overflow, 1);
    do_load(16'h0001, 1'b0, 1'b0, 1'b1);
    check("ovf_cleared_on_accept", overflow, 0);
    tick(2);

    // Blink: 4 cycles value, 4 cycles blank.
    do_load(16'h1234, 1'b0, 1'b0, 1'b1);
    tick(2);
    blink_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      check($sformatf("blink_%0d", i), hex,
            ((i / 4) % 2 == 1) ? ALL_BLANK : exp_disp(16'h1234, 1'b0, 1'b0));
    end
    blink_en = 1'b0;
    tick(2);
    check("blink_off", hex, exp_disp(16'h1234, 1'b0, 1'b0));

    // Reset during conversion aborts it; inputs ignored while in reset.
    do_load(16'h04D2, 1'b1, 1'b0, 1'b0);
    tick(5);
    rst_n      = 1'b0;
    load_value = 16'h00FF;
    mode       = 1'b0;
    load_valid = 1'b1;
    tick(1);
    check("abort_hex", hex, ALL_BLANK);
    check("abort_busy", busy, 0);
    check("abort_ready", load_ready, 1);
    check("abort_ovf", overflow, 0);
    tick(2);
    check("reset_ignores_load", hex, ALL_BLANK);
    rst_n      = 1'b1;
    load_valid = 1'b0;
    tick(20);
    check("abort_no_update", hex, ALL_BLANK);
    check("abort_idle", busy, 0);

    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/hex_display_ctrl.md
HEX_DISPLAY_CTRL -- requirements
Module: hex_display_ctrl

Parameters
REQ-001 The block SHALL have parameter NDIG, default 4, legal range 1..8, giving the number of seven-segment digits driven.
REQ-002 The block SHALL have parameter BLINK_DIV, default 12_500_000, legal range >= 2, giving the number of clock cycles per blink half-period.
REQ-003 The block SHALL have parameter ACTIVE_LOW, default 1: 1 means segment on = 0; 0 inverts every segment output bit.

Interface
REQ-004 The block SHALL have port CLOCK_50, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port RESET_N, input, 1 bit: reset is synchronous and active-low.
REQ-006 The block SHALL have port load_valid, input, 1 bit: a new value is offered.
REQ-007 The block SHALL have port load_ready, output, 1 bit: the block can accept a value.
REQ-008 The block SHALL have port load_value, input, 4*NDIG bits: an unsigned binary value.
REQ-009 The block SHALL have port mode, input, 1 bit: 0 selects hex display, 1 selects decimal display.
REQ-010 The block SHALL have port blank_lz, input, 1 bit: suppress leading zeros.
REQ-011 The block SHALL have port blink_en, input, 1 bit: blink the whole display.
REQ-012 The block SHALL have port busy, output, 1 bit: a decimal conversion is in progress.
REQ-013 The block SHALL have port overflow, output, 1 bit: the last decimal value did not fit in NDIG digits.
REQ-014 The block SHALL have port hex, output, 7*NDIG bits: digit k occupies hex[7k+6:7k], digit 0 is least significant, bit 0 = segment a, bit 6 = segment g; the output is registered.

Function
REQ-015 The block SHALL accept a load when load_valid and load_ready are both 1 on a rising edge; mode and blank_lz SHALL be sampled at the same edge and held until the next accept.
REQ-016 The block SHALL implement a state machine with states IDLE and CONV: load_ready = 1 only in IDLE; busy = 1 only in CONV.
REQ-017 Hex mode: on an accept in IDLE, the block SHALL stay in IDLE, and hex SHALL show the new value on the edge after the accept edge (latency 1); back-to-back accepts on consecutive cycles SHALL be legal.
REQ-018 Decimal mode: on an accept, the block SHALL go to CONV and run a sequential shift-add-3 binary-to-BCD conversion, one bit per cycle, 4*NDIG cycles, using an internal BCD width of NDIG+2 digits.
REQ-019 When the conversion completes, the block SHALL return to IDLE, and hex SHALL update on the same edge; total latency from the accept edge to hex update SHALL be 4*NDIG+1 cycles.
REQ-020 If any BCD digit above NDIG-1 is nonzero after conversion, overflow SHALL be set to 1 and every digit SHALL show dash (g only).
REQ-021 overflow SHALL be cleared to 0 on any subsequent accept.
REQ-022 During CONV, the previously displayed value SHALL remain on hex, and load_valid SHALL be ignored.
REQ-023 Segment codes with ACTIVE_LOW=1, as 7-bit hex, SHALL be: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E dash:3F blank:7F.
REQ-024 With blank_lz=1, every digit above the most significant nonzero digit SHALL show blank; digit 0 SHALL never be blanked by blank_lz (value 0 shows "0").
REQ-025 The block SHALL have a free-running prescaler counting 0..BLINK_DIV-1; on wrap it SHALL toggle blink_phase.
REQ-026 While blink_en=0, the prescaler and blink_phase SHALL be held at 0.
REQ-027 While blink_en=1 and blink_phase=1, all digits SHALL show blank; blink gating SHALL apply to the registered output, with 1-cycle latency from blink_phase.
REQ-028 Between reset and the first completed load, all digits SHALL show blank.

Reset
REQ-029 When RESET_N=0 at a rising edge, on that edge: state = IDLE, load_ready = 1, busy = 0, overflow = 0, prescaler = 0, blink_phase = 0, stored value = 0, every digit = blank (7F).
REQ-030 A reset asserted during CONV SHALL abort the conversion with no hex update other than blanking.
REQ-031 Inputs SHALL be ignored while RESET_N=0.

Verification (NDIG=4, BLINK_DIV=4, ACTIVE_LOW=1)
REQ-032 Reset, then idle for 10 cycles -> hex = 7F7F7F7F per digit, load_ready = 1, busy = 0.
REQ-033 Hex mode, load 0x1A3F -> 1 cycle later, digits 3..0 = 79,08,30,0E.
REQ-034 Hex mode, load 0x000F with blank_lz=1 -> digits = 7F,7F,7F,0E; load 0x0000 -> 7F,7F,7F,40.
REQ-035 Decimal mode, load 0x04D2 -> busy for 16 cycles, load_ready = 0 throughout, a load_valid pulse during CONV is ignored; at cycle 17 the display shows "1234" (79,24,30,19).
REQ-036 Decimal mode, load 0xFFFF -> after 17 cycles, overflow = 1 and all digits = 3F; a following hex load of 0x0001 clears overflow.
REQ-037 blink_en=1 with value 0x1234 -> the display alternates between 4 cycles showing the value and 4 cycles showing blank; reset asserted mid-CONV -> the next cycle shows all blank and busy = 0.
